poly_fill_loader: RTL and testbench
===================================

Name: poly_fill_loader

Overview:
- Sequencer that walks the fixed-coefficient lookup table used to initialise the modulus polynomial for SNTRUP677 inversion (x^p - x - 1).
- Drives the lookup index, consumes the combinational 13-bit coefficient it returns, and writes coefficients 0..P into the inversion working RAM.
- Fetches the special slot at index 2047 (initial loop/degree value P) into a held register for the inversion controller.
- Start/done handshake toward the controller; write port with backpressure toward the RAM arbiter.

Parameters:
- P, 677, polynomial degree; last coefficient index written.
- IDX_W, 11, lookup index / RAM address width.
- DATA_W, 13, coefficient width (two's complement).
- META_IDX, 2047, lookup index of the initial-value slot.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- busy  out  1  high in FILL and META.
- done  out  1  one-cycle pulse when load completes.
- fill_index  out  IDX_W  index to coefficient lookup (registered).
- fill_data  in  DATA_W  combinational lookup result for fill_index, valid same cycle.
- wr_en  out  1  RAM write request.
- wr_ready  in  1  RAM accepts write this cycle when wr_en=1.
- wr_addr  out  IDX_W  RAM address.
- wr_data  out  DATA_W  RAM data.
- meta_value  out  DATA_W  value fetched from META_IDX, held until next load.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, fill_index=0, meta_value=0. Reset wins over every other event, including mid-load; partial RAM contents are not cleaned up.
- States: IDLE, FILL, META, DONE.
- IDLE: start=1 -> FILL, fill_index<=0. start=0 -> stay. start outside IDLE is ignored; no restart or abort.
- Pending write: wr_en=1 and wr_ready=0. While a write is pending, wr_en, wr_addr, wr_data and fill_index hold, and the state does not advance.
- FILL, when no write is pending:
  - wr_en<=1, wr_addr<=fill_index, wr_data<=fill_data.
  - If fill_index==P: fill_index<=META_IDX and state -> META.
  - Otherwise fill_index<=fill_index+1.
- wr_en drops to 0 on the edge that accepts a write when no new write is issued on that edge.
- META: waits until no write is pending, with the last write (addr P) accepted in the same cycle allowed. Then meta_value<=fill_data, wr_en<=0, and state -> DONE. No RAM write is issued for META_IDX.
- DONE: done=1 for exactly one cycle, then IDLE. fill_index<=0 on entry to IDLE.
- Each coefficient is written exactly once, in ascending address order 0..P: P+1 accepted writes per load.
- Latency with wr_ready tied high, start sampled at cycle 0:
  - wr_en high in cycles 2..P+2 (addr 0..P).
  - done high in cycle P+3.
  - busy high in cycles 1..P+2.
- Each cycle of wr_ready=0 while a write is pending adds exactly one cycle to this latency.
- Arithmetic: no wrap of fill_index within 0..P. The jump to META_IDX is explicit, not an increment. fill_data is passed through unmodified, with no sign manipulation.
- meta_value changes only in META; it is stable across IDLE and DONE.

Test Plan:
- Basic load, P=677, wr_ready=1: RAM model receives exactly 678 writes. addr 0 -> 0x1FFF, addr 1 -> 0x1FFF, addr 677 -> 0x0001, all other addrs -> 0x0000. meta_value=677. done pulses once in cycle 680 after start.
- Backpressure: wr_ready=0 for cycles 10-14 and for the cycle presenting addr 677. No write is lost or duplicated, wr_addr/wr_data are stable while stalled, and done is delayed by exactly 6 cycles versus baseline.
- start held high continuously: one load completes, done pulses, and a second load begins from IDLE. start pulses during busy cause no restart and no extra writes.
- Reset mid-FILL (at addr 300): the next cycle shows wr_en=0, busy=0, fill_index=0, meta_value=0. A following start produces a full, clean 678-write load.
- Reset asserted in the same cycle as start in IDLE: stays IDLE with no writes. Reset during META: meta_value=0 and done never pulses.
- Small parameter, P=5 with a matching table model: writes to addrs 0..5 in order, done in cycle 8, meta_value equals the table value at 2047.

Source files
------------

// File: rtl/poly_fill_loader_if.sv
// Handshake and bus bundle between the modulus-polynomial loader, the
// coefficient lookup table, the RAM arbiter and the inversion controller.
interface poly_fill_loader_if #(
  parameter int IDX_W  = 11,
  parameter int DATA_W = 13
);
  logic              start;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  fill_index;
  logic [DATA_W-1:0] fill_data;
  logic              wr_en;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] meta_value;

  // The loader side.
  modport master (
    input  start, fill_data, wr_ready,
    output busy, done, fill_index, wr_en, wr_addr, wr_data, meta_value
  );

  // The environment side: controller, lookup table and RAM arbiter.
  modport slave (
    output start, fill_data, wr_ready,
    input  busy, done, fill_index, wr_en, wr_addr, wr_data, meta_value
  );
endinterface

// File: rtl/poly_fill_loader.sv
// Walks the fixed coefficient table for x^p - x - 1, writes coefficients 0..P
// into the inversion RAM, then captures the initial-value slot at META_IDX.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | issuing one RAM write per accepted cycle, addr 0..P
// META  | draining the addr-P write, then latching the META_IDX lookup
// DONE  | one-cycle done pulse, back to IDLE
module poly_fill_loader #(
  parameter int P        = 677,
  parameter int IDX_W    = 11,
  parameter int DATA_W   = 13,
  parameter int META_IDX = 2047
) (
  input logic               clk,
  input logic               rst,
  poly_fill_loader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(P);
  localparam logic [IDX_W-1:0] META_SLOT = IDX_W'(META_IDX);

  state_t            state_q,      state_d;
  logic [IDX_W-1:0]  fill_index_q, fill_index_d;
  logic              wr_en_q,      wr_en_d;
  logic [IDX_W-1:0]  wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic [DATA_W-1:0] meta_q,       meta_d;
  logic              pending;

  // A write already on the bus that the arbiter has not taken freezes everything.
  assign pending = wr_en_q & ~bus.wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_index_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      meta_q       <= '0;
    end else begin
      state_q      <= state_d;
      fill_index_q <= fill_index_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      meta_q       <= meta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = FILL;
      FILL: if (!pending && fill_index_q == LAST_IDX) state_d = META;
      META: if (!pending) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_index_d = fill_index_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    meta_d       = meta_q;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) fill_index_d = '0;
      end
      FILL: begin
        bus.busy = 1'b1;
        if (!pending) begin
          wr_en_d   = 1'b1;
          wr_addr_d = fill_index_q;
          wr_data_d = bus.fill_data;
          // The jump to the meta slot is explicit; the index never wraps.
          if (fill_index_q == LAST_IDX) fill_index_d = META_SLOT;
          else                          fill_index_d = fill_index_q + IDX_W'(1);
        end
      end
      META: begin
        bus.busy = 1'b1;
        if (!pending) begin
          meta_d  = bus.fill_data;
          wr_en_d = 1'b0;
        end
      end
      DONE: begin
        bus.done     = 1'b1;
        fill_index_d = '0;
      end
      default: begin
        fill_index_d = '0;
        wr_en_d      = 1'b0;
      end
    endcase
  end

  assign bus.fill_index = fill_index_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.meta_value = meta_q;

endmodule

// File: tb/tb_poly_fill_loader.sv
// Randomized bench for poly_fill_loader: a cycle-level load model predicts
// every write, busy/done and meta_value; a second P=5 instance checks scaling.
module tb_poly_fill_loader;

  localparam int PA = 677;
  localparam int PB = 5;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_bb;
  always #5 clk = ~clk;

  poly_fill_loader_if #(.IDX_W(11), .DATA_W(13)) ifa ();
  poly_fill_loader_if #(.IDX_W(11), .DATA_W(13)) ifb ();

  poly_fill_loader #(.P(PA), .IDX_W(11), .DATA_W(13), .META_IDX(2047)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );
  poly_fill_loader #(.P(PB), .IDX_W(11), .DATA_W(13), .META_IDX(2047)) dut_b (
    .clk(clk), .rst(rst_bb), .bus(ifb)
  );

  // Coefficients of x^p - x - 1 in 13-bit two's complement; slot 2047 holds p.
  function automatic logic [12:0] tbl(input logic [10:0] idx, input int p);
    if (idx == 11'd2047) return 13'(p);
    if (idx == 11'(p))   return 13'd1;
    if (idx <= 11'd1)    return 13'h1FFF;
    return 13'd0;
  endfunction

  assign ifa.fill_data = tbl(ifa.fill_index, PA);
  assign ifb.fill_data = tbl(ifb.fill_index, PB);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load model: a load accepts P+1 writes in address order; write k is on the
  // bus from cycle 2 after start until the arbiter takes it.
  bit          active   = 1'b0;
  int          rel      = 0;
  int          acc      = 0;
  logic [12:0] meta_exp = '0;
  int          n_wr     = 0;
  int          n_done   = 0;
  int          done_at  = -1;

  task automatic tick(input bit st, input bit rdy, input bit rs);
    bit we_exp, busy_exp, done_exp;
    @(negedge clk);
    we_exp   = active && rel >= 2 && acc <= PA;
    busy_exp = active && acc <= PA;
    done_exp = active && acc == PA + 1;
    check("busy_done_wren", {29'd0, ifa.busy, ifa.done, ifa.wr_en},
          {29'd0, busy_exp, done_exp, we_exp});
    if (we_exp) begin
      check("wr_addr", 32'(ifa.wr_addr), 32'(acc));
      check("wr_data", 32'(ifa.wr_data), 32'(tbl(11'(acc), PA)));
    end
    check("meta_value", 32'(ifa.meta_value), 32'(meta_exp));
    if (ifa.wr_en && rdy) n_wr++;
    if (ifa.done) begin
      n_done++;
      done_at = rel;
    end
    ifa.start    = st;
    ifa.wr_ready = rdy;
    rst_a        = rs;
    if (rs) begin
      active   = 1'b0;
      acc      = 0;
      meta_exp = '0;
    end else if (!active) begin
      if (st) begin
        active = 1'b1;
        rel    = 1;
        acc    = 0;
      end
    end else if (done_exp) begin
      active = 1'b0;
    end else begin
      if (we_exp && rdy) begin
        acc++;
        if (acc == PA + 1) meta_exp = tbl(11'd2047, PA);
      end
      rel++;
    end
  endtask

  task automatic check_cleared(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_fill_index"}, 32'(ifa.fill_index), 32'd0);
    check({tag, "_wr_en"},      {31'd0, ifa.wr_en},   32'd0);
    check({tag, "_busy"},       {31'd0, ifa.busy},    32'd0);
    check({tag, "_meta"},       32'(ifa.meta_value),  32'd0);
  endtask

  // mode 0: ready tied high, 1: fixed stall pattern, 2: random ready and
  // random start pulses, 3: reset at addr 300, 4: reset during META
  task automatic run_load(input int mode);
    bit st, rdy, rs, stalled_p;
    int guard;
    n_wr      = 0;
    n_done    = 0;
    done_at   = -1;
    stalled_p = 1'b0;
    guard     = 0;
    tick(1'b1, 1'b1, 1'b0);
    while (active && guard < 5000) begin
      st  = 1'b0;
      rdy = 1'b1;
      rs  = 1'b0;
      case (mode)
        1: begin
          if (rel >= 10 && rel <= 14) rdy = 1'b0;
          if (rel >= 2 && acc == PA && !stalled_p) begin
            rdy       = 1'b0;
            stalled_p = 1'b1;
          end
        end
        2: begin
          rdy = ($urandom_range(0, 3) != 0);
          st  = $urandom_range(0, 1) != 0;
        end
        3: rs = (rel >= 2 && acc == 300);
        4: rs = (rel >= 2 && acc == PA);
        default: ;
      endcase
      tick(st, rdy, rs);
      if (rs) check_cleared(mode == 3 ? "rst_fill" : "rst_meta");
      guard++;
    end
    check("load_timeout", {31'd0, active}, 32'd0);
    if (mode <= 2) begin
      check("write_count", 32'(n_wr),   32'(PA + 1));
      check("done_count",  32'(n_done), 32'd1);
    end
    if (mode == 0) check("done_cycle_base",  32'(done_at), 32'(680));
    if (mode == 1) check("done_cycle_stall", 32'(done_at), 32'(686));
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
    if (mode >= 3) check("no_done_after_rst", 32'(n_done), 32'd0);
  endtask

  initial begin
    int guard;
    int qb[$];
    int done_b;
    ifa.start    = 1'b0;
    ifa.wr_ready = 1'b1;
    ifb.start    = 1'b0;
    ifb.wr_ready = 1'b1;
    rst_a        = 1'b1;
    rst_bb       = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("rst_fill_index", 32'(ifa.fill_index), 32'd0);
    check("rst_wr_addr",    32'(ifa.wr_addr),    32'd0);
    check("rst_wr_data",    32'(ifa.wr_data),    32'd0);
    check("rst_outputs", {28'd0, ifa.busy, ifa.done, ifa.wr_en, 1'b0}, 32'd0);
    tick(1'b0, 1'b1, 1'b0);

    run_load(0);
    run_load(1);
    run_load(2);
    run_load(2);

    // start held high across two complete loads
    n_wr   = 0;
    n_done = 0;
    guard  = 0;
    while (n_done < 2 && guard < 4000) begin
      tick(1'b1, $urandom_range(0, 3) != 0, 1'b0);
      guard++;
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
    check("held_done_count",  32'(n_done), 32'd2);
    check("held_write_count", 32'(n_wr),   32'(2 * (PA + 1)));

    run_load(3);
    run_load(0);

    // reset and start in the same IDLE cycle
    n_wr = 0;
    tick(1'b1, 1'b1, 1'b1);
    check_cleared("rst_start");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    check("rst_start_writes", 32'(n_wr), 32'd0);

    run_load(4);

    // P=5 instance, ready tied high
    @(negedge clk);
    rst_bb = 1'b0;
    @(negedge clk);
    ifb.start = 1'b1;
    done_b    = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ifb.start = 1'b0;
      if (ifb.wr_en) begin
        qb.push_back(int'(ifb.wr_addr));
        check("b_wr_data", 32'(ifb.wr_data), 32'(tbl(ifb.wr_addr, PB)));
      end
      if (ifb.done) done_b = k;
    end
    check("b_write_count", 32'(qb.size()), 32'(PB + 1));
    for (int i = 0; i < qb.size(); i++) check("b_wr_order", 32'(qb[i]), 32'(i));
    check("b_done_cycle", 32'(done_b), 32'd8);
    check("b_meta", 32'(ifb.meta_value), 32'(tbl(11'd2047, PB)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
